// File: rtl/gshare_predictor.sv
// Two-wide gshare conditional-branch predictor: PC^history indexed table of
// saturating counters, speculative global history, sequential dual-retire update.
module gshare_predictor #(
  parameter int IDX_BITS  = 8,
  parameter int HIST_BITS = 8,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 ready,
  input  logic                 fetch_cond0,
  input  logic                 fetch_cond1,
  input  logic [63:0]          fetch_pc0,
  input  logic [63:0]          fetch_pc1,
  input  logic                 fetch_stall,
  output logic                 pred_taken0,
  output logic                 pred_taken1,
  output logic [HIST_BITS-1:0] pred_hist0,
  output logic [HIST_BITS-1:0] pred_hist1,
  input  logic                 recover_valid,
  input  logic [HIST_BITS-1:0] recover_hist,
  input  logic                 recover_taken,
  input  logic                 ret_valid0,
  input  logic                 ret_valid1,
  input  logic [63:0]          ret_pc0,
  input  logic [63:0]          ret_pc1,
  input  logic [HIST_BITS-1:0] ret_hist0,
  input  logic [HIST_BITS-1:0] ret_hist1,
  input  logic                 ret_taken0,
  input  logic                 ret_taken1
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t               state, state_nxt;
  logic [IDX_BITS-1:0]  init_cnt, init_cnt_nxt;
  logic [HIST_BITS-1:0] hist_reg, hist_nxt;
  logic [CTR_BITS-1:0]  pht [ENTRIES];

  // Widening to HIST_BITS+1 makes the HIST_BITS=1 case fall out naturally.
  function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h, input logic b);
    logic [HIST_BITS:0] t;
    t = {h, b};
    return t[HIST_BITS-1:0];
  endfunction

  function automatic logic [IDX_BITS-1:0] pht_idx(input logic [IDX_BITS-1:0] pc_bits,
                                                  input logic [HIST_BITS-1:0] h);
    logic [IDX_BITS-1:0] hz;
    hz = '0;
    hz[HIST_BITS-1:0] = h;
    return pc_bits ^ hz;
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (&c) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic                     run;
  logic [HIST_BITS-1:0]     h_base, h_slot1, h_fetch;
  logic [1:0][IDX_BITS-1:0] fidx, ridx;
  logic                     t0, t1, sup1;
  logic [CTR_BITS-1:0]      ret_ctr1, ret_nxt0, ret_nxt1;
  logic                     unused_pc_bits;

  assign run   = (state == RUN);
  assign ready = run;
  assign unused_pc_bits = ^{fetch_pc0[63:IDX_BITS+2], fetch_pc0[1:0], fetch_pc1[63:IDX_BITS+2],
                            fetch_pc1[1:0], ret_pc0[63:IDX_BITS+2], ret_pc0[1:0],
                            ret_pc1[63:IDX_BITS+2], ret_pc1[1:0]};

  // Fetch path: slot 1 sees slot 0's predicted outcome, and is dead if slot 0 branches away.
  always_comb begin
    h_base  = recover_valid ? shift_in(recover_hist, recover_taken) : hist_reg;
    fidx[0] = pht_idx(fetch_pc0[IDX_BITS+1:2], h_base);
    t0      = pht[fidx[0]][CTR_BITS-1];
    h_slot1 = fetch_cond0 ? shift_in(h_base, t0) : h_base;
    sup1    = fetch_cond0 & t0;
    fidx[1] = pht_idx(fetch_pc1[IDX_BITS+1:2], h_slot1);
    t1      = ~sup1 & pht[fidx[1]][CTR_BITS-1];
    h_fetch = (fetch_cond1 & ~sup1) ? shift_in(h_slot1, t1) : h_slot1;

    pred_taken0 = run & t0;
    pred_taken1 = run & t1;
    pred_hist0  = run ? h_base  : '0;
    pred_hist1  = run ? h_slot1 : '0;
  end

  // Retire path: a same-index ret1 builds on ret0's result, saturating at each step.
  always_comb begin
    ridx[0]  = pht_idx(ret_pc0[IDX_BITS+1:2], ret_hist0);
    ridx[1]  = pht_idx(ret_pc1[IDX_BITS+1:2], ret_hist1);
    ret_nxt0 = sat_step(pht[ridx[0]], ret_taken0);
    ret_ctr1 = (ret_valid0 && ridx[1] == ridx[0]) ? ret_nxt0 : pht[ridx[1]];
    ret_nxt1 = sat_step(ret_ctr1, ret_taken1);
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    hist_nxt     = '0;
    case (state)
      INIT: begin
        init_cnt_nxt = flush ? '0 : init_cnt + 1'b1;
        if (!flush && (&init_cnt)) state_nxt = RUN;
      end
      RUN: begin
        init_cnt_nxt = '0;
        if (flush) state_nxt = INIT;
        else       hist_nxt  = fetch_stall ? h_base : h_fetch;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      hist_reg <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      hist_reg <= hist_nxt;
    end
  end

  // Table has no reset; INIT sweeps every entry to weakly-not-taken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!run) begin
        pht[init_cnt] <= CTR_WNT;
      end else begin
        if (ret_valid0) pht[ridx[0]] <= ret_nxt0;
        if (ret_valid1) pht[ridx[1]] <= ret_nxt1;
      end
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: default-size predictor for function, IDX_BITS=4 copy for INIT timing.
module tb_gshare_predictor;
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, fetch_cond0, fetch_cond1, fetch_stall;
  logic [63:0] fetch_pc0, fetch_pc1, ret_pc0, ret_pc1;
  logic        recover_valid, recover_taken, ret_valid0, ret_valid1, ret_taken0, ret_taken1;
  logic [7:0]  recover_hist, ret_hist0, ret_hist1;
  logic        ready, pred_taken0, pred_taken1;
  logic [7:0]  pred_hist0, pred_hist1;
  logic        ready_s, pt0_s, pt1_s;
  logic [3:0]  ph0_s, ph1_s;

  gshare_predictor dut (
    .clock(clock), .reset(reset), .flush(flush), .ready(ready),
    .fetch_cond0(fetch_cond0), .fetch_cond1(fetch_cond1), .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
    .fetch_stall(fetch_stall), .pred_taken0(pred_taken0), .pred_taken1(pred_taken1),
    .pred_hist0(pred_hist0), .pred_hist1(pred_hist1),
    .recover_valid(recover_valid), .recover_hist(recover_hist), .recover_taken(recover_taken),
    .ret_valid0(ret_valid0), .ret_valid1(ret_valid1), .ret_pc0(ret_pc0), .ret_pc1(ret_pc1),
    .ret_hist0(ret_hist0), .ret_hist1(ret_hist1), .ret_taken0(ret_taken0), .ret_taken1(ret_taken1));

  gshare_predictor #(.IDX_BITS(4), .HIST_BITS(4), .CTR_BITS(2)) dut_s (
    .clock(clock), .reset(reset), .flush(flush), .ready(ready_s),
    .fetch_cond0(fetch_cond0), .fetch_cond1(fetch_cond1), .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
    .fetch_stall(fetch_stall), .pred_taken0(pt0_s), .pred_taken1(pt1_s),
    .pred_hist0(ph0_s), .pred_hist1(ph1_s),
    .recover_valid(recover_valid), .recover_hist(recover_hist[3:0]), .recover_taken(recover_taken),
    .ret_valid0(ret_valid0), .ret_valid1(ret_valid1), .ret_pc0(ret_pc0), .ret_pc1(ret_pc1),
    .ret_hist0(ret_hist0[3:0]), .ret_hist1(ret_hist1[3:0]), .ret_taken0(ret_taken0), .ret_taken1(ret_taken1));

  int checks = 0, errors = 0;

  typedef struct {
    logic [7:0]  h;
    logic        rv;  logic [7:0] rh; logic rt;
    logic        c0, c1;
    logic [63:0] pc0, pc1;
    logic        st;
    logic        e_t0, e_t1;
    logic [7:0]  e_h0, e_h1, e_nh;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    flush = 0; fetch_cond0 = 0; fetch_cond1 = 0; fetch_pc0 = 0; fetch_pc1 = 0; fetch_stall = 1;
    recover_valid = 0; recover_hist = 0; recover_taken = 0;
    ret_valid0 = 0; ret_valid1 = 0; ret_pc0 = 0; ret_pc1 = 0;
    ret_hist0 = 0; ret_hist1 = 0; ret_taken0 = 0; ret_taken1 = 0;
  endtask

  // Look up slot 0 with history forced to 0 via recovery; stall keeps the bundle out of history.
  task automatic probe(input logic [63:0] pc, input logic exp, input string name);
    recover_valid = 1; recover_hist = 0; recover_taken = 0;
    fetch_cond0 = 1; fetch_pc0 = pc; fetch_stall = 1;
    #1 check(name, 64'(pred_taken0), 64'(exp));
    tick(); idle();
  endtask

  task automatic retire(input logic [63:0] pc, input logic t);
    ret_valid0 = 1; ret_pc0 = pc; ret_hist0 = 0; ret_taken0 = t;
    tick(); idle();
  endtask

  // Counts edges until the small instance is ready; bound expiry shows as a wrong count.
  task automatic wait_ready_s(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (ready_s) begin n = i; break; end
    end
  endtask

  initial begin
    int n, n_s, n_b;
    //          h     rv rh     rt c0 c1 pc0    pc1    st  t0 t1 h0     h1     nh
    vecs[0] = '{8'h05, 0, 8'h00, 0, 1, 1, 64'h00, 64'h38, 0, 0, 1, 8'h05, 8'h0A, 8'h15};
    vecs[1] = '{8'h00, 1, 8'h0F, 1, 1, 0, 64'h6C, 64'h00, 0, 1, 0, 8'h1F, 8'h3F, 8'h3F};
    vecs[2] = '{8'h00, 0, 8'h00, 0, 1, 1, 64'h10, 64'h24, 0, 1, 0, 8'h00, 8'h01, 8'h01};
    vecs[3] = '{8'h05, 0, 8'h00, 0, 1, 1, 64'h00, 64'h38, 1, 0, 1, 8'h05, 8'h0A, 8'h05};
    vecs[4] = '{8'h03, 0, 8'h00, 0, 0, 1, 64'h00, 64'h3C, 0, 0, 1, 8'h03, 8'h03, 8'h07};
    vecs[5] = '{8'h80, 0, 8'h00, 0, 1, 1, 64'h00, 64'h100, 0, 0, 0, 8'h80, 8'h00, 8'h00};
    vecs[6] = '{8'h00, 1, 8'hAA, 0, 1, 0, 64'h00, 64'h00, 1, 0, 0, 8'h54, 8'hA8, 8'h54};

    idle(); reset = 1;
    tick(); tick();
    fetch_cond0 = 1; fetch_cond1 = 1; fetch_pc0 = 64'h1234; recover_valid = 1; recover_hist = 8'hFF; recover_taken = 1;
    #1;
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_pt0", 64'(pred_taken0), 64'(0));
    check("reset_ph0", 64'(pred_hist0), 64'(0));
    check("reset_ph1", 64'(pred_hist1), 64'(0));
    reset = 0;
    #1 check("init_ignores_recover", 64'(pred_hist0), 64'(0));
    idle();

    n_s = 0; n_b = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (ready_s && n_s == 0) n_s = i;
      if (ready) begin n_b = i; break; end
    end
    check("ready_rise_idx4", 64'(n_s), 64'(16));
    check("ready_rise_idx8", 64'(n_b), 64'(256));

    fetch_cond0 = 1; fetch_pc0 = 64'h1234;
    #1;
    check("first_fetch_taken_s", 64'(pt0_s), 64'(0));
    check("first_fetch_hist_s", 64'(ph0_s), 64'(0));
    check("first_fetch_taken", 64'(pred_taken0), 64'(0));
    check("first_fetch_hist", 64'(pred_hist0), 64'(0));
    tick(); idle();

    // Single-port training and saturation at idx 4 (pc 0x10, hist 0).
    retire(64'h10, 1); retire(64'h10, 1); probe(64'h10, 1, "train_2T");
    retire(64'h10, 1); retire(64'h10, 0); probe(64'h10, 1, "sat_hi_then_NT");
    retire(64'h10, 0); retire(64'h10, 0); retire(64'h10, 0);
    retire(64'h10, 1); probe(64'h10, 0, "sat_lo_then_T");
    retire(64'h10, 1); probe(64'h10, 1, "sat_lo_then_2T");

    // Retire write is not bypassed into a same-cycle fetch.
    ret_valid0 = 1; ret_pc0 = 64'h50; ret_taken0 = 1;
    recover_valid = 1; fetch_cond0 = 1; fetch_pc0 = 64'h50;
    #1 check("no_bypass", 64'(pred_taken0), 64'(0));
    tick(); idle();
    probe(64'h50, 1, "retire_visible_next");

    // Dual retire to one index, applied sequentially.
    ret_valid0 = 1; ret_pc0 = 64'h20; ret_taken0 = 1;
    ret_valid1 = 1; ret_pc1 = 64'h20; ret_taken1 = 1;
    tick(); idle();
    probe(64'h20, 1, "dual_TT");
    retire(64'h20, 0); probe(64'h20, 1, "dual_TT_is_3");
    ret_valid0 = 1; ret_pc0 = 64'h30; ret_taken0 = 1;
    ret_valid1 = 1; ret_pc1 = 64'h30; ret_taken1 = 0;
    tick(); idle();
    probe(64'h30, 0, "dual_TN");
    retire(64'h30, 1); probe(64'h30, 1, "dual_TN_is_1");

    // Fetch/history vectors: preset hist_reg, apply bundle, observe next hist_reg.
    for (int v = 0; v < 7; v++) begin
      recover_valid = 1; recover_hist = {1'b0, vecs[v].h[7:1]}; recover_taken = vecs[v].h[0];
      tick(); idle();
      recover_valid = vecs[v].rv; recover_hist = vecs[v].rh; recover_taken = vecs[v].rt;
      fetch_cond0 = vecs[v].c0; fetch_cond1 = vecs[v].c1;
      fetch_pc0 = vecs[v].pc0; fetch_pc1 = vecs[v].pc1; fetch_stall = vecs[v].st;
      #1;
      check($sformatf("v%0d_pt0", v), 64'(pred_taken0), 64'(vecs[v].e_t0));
      check($sformatf("v%0d_pt1", v), 64'(pred_taken1), 64'(vecs[v].e_t1));
      check($sformatf("v%0d_ph0", v), 64'(pred_hist0), 64'(vecs[v].e_h0));
      check($sformatf("v%0d_ph1", v), 64'(pred_hist1), 64'(vecs[v].e_h1));
      tick(); idle();
      #1 check($sformatf("v%0d_next_hist", v), 64'(pred_hist0), 64'(vecs[v].e_nh));
    end

    // Flush in RUN; retires during INIT must vanish.
    flush = 1;
    tick(); idle();
    check("flush_ready", 64'(ready), 64'(0));
    check("flush_ready_s", 64'(ready_s), 64'(0));
    n_s = 0; n_b = 0;
    for (int i = 1; i <= 400; i++) begin
      ret_valid0 = 1; ret_pc0 = 64'h10; ret_taken0 = 1;
      ret_valid1 = 1; ret_pc1 = 64'h40; ret_taken1 = 1;
      tick();
      if (ready_s && n_s == 0) n_s = i;
      if (ready) begin n_b = i; break; end
    end
    idle();
    check("flush_rise_idx4", 64'(n_s), 64'(16));
    check("flush_rise_idx8", 64'(n_b), 64'(256));
    fetch_cond0 = 1; fetch_pc0 = 64'h10;
    #1;
    check("flush_hist_cleared", 64'(pred_hist0), 64'(0));
    check("flush_idx4_reinit", 64'(pred_taken0), 64'(0));
    tick(); idle();
    probe(64'h40, 0, "flush_init_retire_ignored");

    // Flush during INIT restarts the sweep.
    flush = 1; tick(); idle();
    repeat (5) tick();
    flush = 1; tick(); idle();
    wait_ready_s(n);
    check("flush_in_init_restart", 64'(n), 64'(16));

    // Reset while running restarts INIT.
    reset = 1; tick(); reset = 0;
    check("reset_in_run_ready", 64'(ready_s), 64'(0));
    wait_ready_s(n);
    check("reset_in_run_rise", 64'(n), 64'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 8, log2 of pattern-table entries.
REQ-002 SHALL have parameter HIST_BITS, default 8, global history length; legal range 1..IDX_BITS.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating-counter width; legal range 2..4.
REQ-004 SHALL have port clock  in  1  clock; reset reset, synchronous, active-high; clock clock.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port flush  in  1  one-cycle pulse; re-initialises the table.
REQ-007 SHALL have port ready  out  1  high when table is initialised and predicting.
REQ-008 SHALL have ports fetch_cond0/fetch_cond1  in  1 each  slot holds a conditional branch.
REQ-009 SHALL have ports fetch_pc0/fetch_pc1  in  64 each  slot PCs.
REQ-010 SHALL have port fetch_stall  in  1  fetch bundle not consumed this cycle.
REQ-011 SHALL have ports pred_taken0/pred_taken1  out  1 each  prediction per slot.
REQ-012 SHALL have ports pred_hist0/pred_hist1  out  HIST_BITS each  history used for the slot; travels with the branch to retire.
REQ-013 SHALL have ports recover_valid  in  1, recover_hist  in  HIST_BITS, recover_taken  in  1  mispredict repair.
REQ-014 SHALL have ports ret_valid0/1  in  1, ret_pc0/1  in  64, ret_hist0/1  in  HIST_BITS, ret_taken0/1  in  1  retired conditional branches.

Function
REQ-015 SHALL index the table as fetch/ret pc[IDX_BITS+1:2] XOR history zero-extended to IDX_BITS.
REQ-016 SHALL predict taken iff counter MSB is 1.
REQ-017 SHALL produce pred_* combinationally in the same cycle as fetch_*, using the table value at the start of the cycle.
REQ-018 SHALL form base history H = recover_valid ? {recover_hist[HIST_BITS-2:0], recover_taken} : hist_reg; for HIST_BITS=1, H = recover_taken.
REQ-019 Slot 0: pred_hist0 = H; pred_taken0 is looked up with H.
REQ-020 Slot 1: pred_hist1 = H1, where H1 = {H shifted, pred_taken0} if fetch_cond0, else H1 = H; pred_taken1 is looked up with H1.
REQ-021 Slot 1 SHALL be suppressed (pred_taken1=0, no shift) when fetch_cond0 and pred_taken0 are both 1, because slot 1 is then on the wrong path.
REQ-022 Next hist_reg: H plus one shift per valid, unsuppressed slot (0, 1 or 2 shifts); when fetch_stall=1, hist_reg <= H (recovery still applies, fetch shifts do not).
REQ-023 Retire updates: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_BITS-1; indexed with ret_hist, not hist_reg.
REQ-024 When both retires hit the same index in one cycle, SHALL apply ret0 then ret1 sequentially; net change in -2..+2, saturating at each step.
REQ-025 Retire writes SHALL be visible to fetch the next cycle; no same-cycle bypass.
REQ-026 SHALL implement a two-state FSM: INIT and RUN.
REQ-027 INIT: one entry per cycle is written to weakly-not-taken (2^(CTR_BITS-1)-1), with a counter running 0..2^IDX_BITS-1; after the last entry the FSM goes to RUN; INIT lasts exactly 2^IDX_BITS cycles.
REQ-028 In INIT: ready=0, pred_taken*=0, pred_hist*=0, hist_reg held at 0, retire and recover inputs ignored.
REQ-029 flush in RUN SHALL enter INIT at counter 0 next cycle and clear hist_reg; flush in INIT SHALL restart the counter at 0.
REQ-030 In RUN: ready=1.

Reset
REQ-031 On reset: FSM=INIT, init counter=0, hist_reg=0, ready=0, pred_taken*=0, pred_hist*=0; a reset asserted mid-INIT or mid-RUN restarts INIT.
REQ-032 Table contents SHALL be defined only after INIT completes; no per-entry reset is required.

Verification
REQ-033 Reset, IDX_BITS=4: ready rises exactly 16 cycles after reset deasserts; the first fetch at any PC then predicts not-taken with pred_hist0=0.
REQ-034 Retire pc=0x10, hist=0, taken, twice across 2 cycles: fetch pc=0x10 with hist=0 then predicts taken; a third taken retire leaves the counter at 3; four not-taken retires saturate it at 0.
REQ-035 Same-cycle ret0 and ret1 at the same index, both taken, from counter 1: counter becomes 3; with one taken and one not-taken, it stays 1.
REQ-036 hist_reg=0b0000_0101, both slots cond, slot0 predicts not-taken: pred_hist1=0b0000_1010, and hist_reg next = 0b0001_010x, where x = pred_taken1.
REQ-037 recover_valid with recover_hist=0x0F, recover_taken=1, and concurrent slot0-only fetch predicting taken: pred_hist0=0x1F and hist_reg next = 0x3F.
REQ-038 flush pulse in RUN: ready=0 the next cycle, ready=1 again after 2^IDX_BITS cycles; retires issued during INIT leave no trace.
